// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch stage: reset constants, 2-bit counter
// encodings, the PC-source enum and the saturating counter step.
package cpu_pkg;

    localparam logic [31:0] CPU_NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] CPU_RESET_PC  = 32'h0000_0000;

    localparam logic [1:0] CNT_SNT = 2'b00;
    localparam logic [1:0] CNT_WNT = 2'b01;
    localparam logic [1:0] CNT_WT  = 2'b10;
    localparam logic [1:0] CNT_ST  = 2'b11;

    typedef enum logic [1:0] {
        SRC_FETCH,
        SRC_HOLD,
        SRC_ID,
        SRC_EX
    } redirect_src_e;

    function automatic logic [1:0] cnt_step(input logic [1:0] cnt, input logic taken);
        logic [1:0] res;
        res = cnt;
        if (taken && cnt != CNT_ST)
            res = cnt + 2'b01;
        else if (!taken && cnt != CNT_SNT)
            res = cnt - 2'b01;
        return res;
    endfunction

endpackage

// File: rtl/bht_btb.sv
// Direct-mapped 2-bit branch history table with tagged target buffer:
// combinational lookup from registered tables, synchronous update port.
module bht_btb
    import cpu_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] lookup_pc,
    output logic        lookup_taken,
    output logic [31:0] lookup_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target
);
    localparam int TAG_W = 30 - IDX_W;
    localparam int N     = 1 << IDX_W;

    logic [1:0]       r_cnt [N];
    logic             r_vld [N];
    logic [TAG_W-1:0] r_tag [N];
    logic [31:0]      r_tgt [N];

    logic [IDX_W-1:0] w_lk_idx;
    logic [IDX_W-1:0] w_up_idx;
    logic             w_lk_hit;
    logic             w_up_hit;
    logic             w_alloc;
    logic             w_unused;

    assign w_lk_idx = lookup_pc[IDX_W+1:2];
    assign w_up_idx = upd_pc[IDX_W+1:2];
    assign w_lk_hit = r_vld[w_lk_idx] && (r_tag[w_lk_idx] == lookup_pc[31:IDX_W+2]);
    assign w_up_hit = r_vld[w_up_idx] && (r_tag[w_up_idx] == upd_pc[31:IDX_W+2]);
    assign w_alloc  = upd_valid && !w_up_hit && upd_taken;
    assign w_unused = ^{lookup_pc[1:0], upd_pc[1:0]};

    assign lookup_taken  = w_lk_hit && r_cnt[w_lk_idx][1];
    assign lookup_target = r_tgt[w_lk_idx];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                r_cnt[i] <= CNT_WNT;
                r_vld[i] <= 1'b0;
            end
        end else if (upd_valid) begin
            if (w_up_hit) begin
                r_cnt[w_up_idx] <= cnt_step(r_cnt[w_up_idx], upd_taken);
            end else if (upd_taken) begin
                r_cnt[w_up_idx] <= CNT_WT;
                r_vld[w_up_idx] <= 1'b1;
            end
        end
    end

    // Tag and target need no reset: they are only read behind a valid bit.
    always_ff @(posedge clk) begin
        if (rst_n && (w_alloc || (upd_valid && w_up_hit && upd_taken)))
            r_tgt[w_up_idx] <= upd_target;
        if (rst_n && w_alloc)
            r_tag[w_up_idx] <= upd_pc[31:IDX_W+2];
    end

endmodule

// File: rtl/fetch_predict_stage.sv
// Instruction fetch with PC register, redirect/stall priority and IF/ID register.
// Define FETCH_PREDICT_EN to build in the bht_btb predictor; otherwise fetch is PC+4.
module fetch_predict_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = CPU_RESET_PC,
    parameter int          IDX_W     = 4,
    parameter logic [31:0] NOP_INSTR = CPU_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        id_redirect,
    input  logic [31:0] id_redirect_pc,
    input  logic        ex_redirect,
    input  logic [31:0] ex_redirect_pc,
    input  logic        ex_br_valid,
    input  logic [31:0] ex_br_pc,
    input  logic        ex_br_taken,
    input  logic [31:0] ex_br_target,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic        if_id_pred_taken,
    output logic [31:0] if_id_pred_target,
    output logic        if_id_valid
);
    logic [31:0]   r_pc;
    logic [31:0]   r_instr;
    logic [31:0]   r_if_pc;
    logic          r_pred_taken;
    logic [31:0]   r_pred_target;
    logic          r_valid;

    logic          w_pred_taken;
    logic [31:0]   w_btb_target;
    logic [31:0]   w_pred_next;
    redirect_src_e w_src;

`ifdef FETCH_PREDICT_EN
    bht_btb #(.IDX_W(IDX_W)) u_bht_btb (
        .clk           (clk),
        .rst_n         (rst_n),
        .lookup_pc     (r_pc),
        .lookup_taken  (w_pred_taken),
        .lookup_target (w_btb_target),
        .upd_valid     (ex_br_valid),
        .upd_pc        (ex_br_pc),
        .upd_taken     (ex_br_taken),
        .upd_target    (ex_br_target)
    );
`else
    logic w_unused;
    assign w_unused     = ^{ex_br_valid, ex_br_pc, ex_br_taken, ex_br_target};
    assign w_pred_taken = 1'b0;
    assign w_btb_target = 32'h0;
`endif

    assign w_pred_next = w_pred_taken ? w_btb_target : r_pc + 32'd4;

    // EX redirect outranks stall; an ID redirect is only honoured when not stalled.
    always_comb begin
        w_src = SRC_FETCH;
        if (ex_redirect)
            w_src = SRC_EX;
        else if (id_redirect && !stall)
            w_src = SRC_ID;
        else if (stall)
            w_src = SRC_HOLD;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_instr       <= NOP_INSTR;
            r_if_pc       <= 32'h0;
            r_pred_taken  <= 1'b0;
            r_pred_target <= 32'h0;
            r_valid       <= 1'b0;
        end else begin
            case (w_src)
                SRC_EX, SRC_ID: begin
                    r_pc          <= (w_src == SRC_EX) ? ex_redirect_pc : id_redirect_pc;
                    r_instr       <= NOP_INSTR;
                    r_if_pc       <= 32'h0;
                    r_pred_taken  <= 1'b0;
                    r_pred_target <= 32'h0;
                    r_valid       <= 1'b0;
                end
                SRC_HOLD: begin
                    r_pc <= r_pc;
                end
                default: begin
                    r_pc          <= w_pred_next;
                    r_instr       <= imem_data;
                    r_if_pc       <= r_pc;
                    r_pred_taken  <= w_pred_taken;
                    r_pred_target <= w_pred_taken ? w_btb_target : 32'h0;
                    r_valid       <= 1'b1;
                end
            endcase
        end
    end

    assign imem_addr         = r_pc;
    assign if_id_instr       = r_instr;
    assign if_id_pc          = r_if_pc;
    assign if_id_pred_taken  = r_pred_taken;
    assign if_id_pred_target = r_pred_target;
    assign if_id_valid       = r_valid;

endmodule

// File: tb/tb_fetch_predict_stage.sv
// Scoreboard bench for fetch_predict_stage: directed vectors push expectations,
// a negedge monitor pops and compares. Prediction expectations follow FETCH_PREDICT_EN.
module tb_fetch_predict_stage;

`ifdef FETCH_PREDICT_EN
    localparam bit PRED = 1'b1;
`else
    localparam bit PRED = 1'b0;
`endif
    localparam logic [31:0] P_ADDR = PRED ? 32'h40 : 32'h14;
    localparam logic [31:0] P_TGT  = PRED ? 32'h40 : 32'h0;
    localparam logic        P_PT   = PRED;

    logic        clk = 1'b0;
    logic        rst_n, stall, id_redirect, ex_redirect, ex_br_valid, ex_br_taken;
    logic [31:0] imem_addr, imem_data, id_redirect_pc, ex_redirect_pc, ex_br_pc, ex_br_target;
    logic [31:0] if_id_instr, if_id_pc, if_id_pred_target;
    logic        if_id_pred_taken, if_id_valid;

    always #5 clk = ~clk;

    // Memory contents are a simple function of the address.
    assign imem_data = 32'hC000_0000 | imem_addr;

    fetch_predict_stage dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .stall             (stall),
        .imem_addr         (imem_addr),
        .imem_data         (imem_data),
        .id_redirect       (id_redirect),
        .id_redirect_pc    (id_redirect_pc),
        .ex_redirect       (ex_redirect),
        .ex_redirect_pc    (ex_redirect_pc),
        .ex_br_valid       (ex_br_valid),
        .ex_br_pc          (ex_br_pc),
        .ex_br_taken       (ex_br_taken),
        .ex_br_target      (ex_br_target),
        .if_id_instr       (if_id_instr),
        .if_id_pc          (if_id_pc),
        .if_id_pred_taken  (if_id_pred_taken),
        .if_id_pred_target (if_id_pred_target),
        .if_id_valid       (if_id_valid)
    );

    typedef struct {
        int          id;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        pt;
        logic [31:0] tgt;
        logic        v;
        logic        mask;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   vec_id   = 0;

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s vec%0d: got %h expected %h", nm, id, act, exp);
    endtask

    // Monitor: one comparison set per pushed transaction, sampled on negedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                $display("vec %0d: addr=%h instr=%h pc=%h pt=%0d tgt=%h v=%0d",
                         e.id, imem_addr, if_id_instr, if_id_pc, if_id_pred_taken,
                         if_id_pred_target, if_id_valid);
                chk("imem_addr", e.id, imem_addr, e.addr);
                chk("if_id_valid", e.id, {31'b0, if_id_valid}, {31'b0, e.v});
                chk("if_id_instr", e.id, if_id_instr, e.instr);
                chk("if_id_pred_taken", e.id, {31'b0, if_id_pred_taken}, {31'b0, e.pt});
                if (!e.mask) begin
                    chk("if_id_pc", e.id, if_id_pc, e.pc);
                    chk("if_id_pred_target", e.id, if_id_pred_target, e.tgt);
                end
            end
        end
    end

    task automatic vec(input logic rs, input logic st, input logic idr, input logic [31:0] idpc,
                       input logic exr, input logic [31:0] expc, input logic brv, input logic brt,
                       input logic [31:0] e_addr, input logic [31:0] e_instr, input logic [31:0] e_pc,
                       input logic e_pt, input logic [31:0] e_tgt, input logic e_v, input logic e_mask);
        exp_t e;
        rst_n          = rs;
        stall          = st;
        id_redirect    = idr;
        id_redirect_pc = idpc;
        ex_redirect    = exr;
        ex_redirect_pc = expc;
        ex_br_valid    = brv;
        ex_br_taken    = brt;
        @(posedge clk);
        #1;
        e.id = vec_id; e.addr = e_addr; e.instr = e_instr; e.pc = e_pc;
        e.pt = e_pt; e.tgt = e_tgt; e.v = e_v; e.mask = e_mask;
        sb.push_back(e);
        vec_id++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        ex_br_pc     = 32'h10;
        ex_br_target = 32'h40;
        // Reset state
        vec(0,0,0,0,      0,0,      0,0, 32'h0, 32'h0, 32'h0, 0, 32'h0, 0, 0);
        vec(0,0,0,0,      0,0,      0,0, 32'h0, 32'h0, 32'h0, 0, 32'h0, 0, 0);
        // Sequential fetch, 1-cycle latency
        vec(1,0,0,0,      0,0,      0,0, 32'h4, 32'hC000_0000, 32'h0, 0, 32'h0, 1, 0);
        vec(1,0,0,0,      0,0,      0,0, 32'h8, 32'hC000_0004, 32'h4, 0, 32'h0, 1, 0);
        // Stall holds PC and IF/ID
        vec(1,1,0,0,      0,0,      0,0, 32'h8, 32'hC000_0004, 32'h4, 0, 32'h0, 1, 0);
        vec(1,1,0,0,      0,0,      0,0, 32'h8, 32'hC000_0004, 32'h4, 0, 32'h0, 1, 0);
        vec(1,0,0,0,      0,0,      0,0, 32'hC, 32'hC000_0008, 32'h8, 0, 32'h0, 1, 0);
        // Train branch at 0x10 taken to 0x40 twice while stalled
        vec(1,1,0,0,      0,0,      1,1, 32'hC, 32'hC000_0008, 32'h8, 0, 32'h0, 1, 0);
        vec(1,1,0,0,      0,0,      1,1, 32'hC, 32'hC000_0008, 32'h8, 0, 32'h0, 1, 0);
        vec(1,0,0,0,      0,0,      0,0, 32'h10, 32'hC000_000C, 32'hC, 0, 32'h0, 1, 0);
        vec(1,0,0,0,      0,0,      0,0, P_ADDR, 32'hC000_0010, 32'h10, P_PT, P_TGT, 1, 0);
        // EX redirect overrides stall
        vec(1,1,0,0,      1,32'h80, 0,0, 32'h80, 32'h0, 32'h0, 0, 32'h0, 0, 1);
        // ID redirect ignored under stall, honoured without
        vec(1,1,1,32'h100,0,0,      0,0, 32'h80, 32'h0, 32'h0, 0, 32'h0, 0, 1);
        vec(1,0,1,32'h100,0,0,      0,0, 32'h100, 32'h0, 32'h0, 0, 32'h0, 0, 1);
        vec(1,0,0,0,      0,0,      0,0, 32'h104, 32'hC000_0100, 32'h100, 0, 32'h0, 1, 0);
        // Taken at ST stays ST, then one not-taken gives WT (still predicts taken)
        vec(1,1,0,0,      0,0,      1,1, 32'h104, 32'hC000_0100, 32'h100, 0, 32'h0, 1, 0);
        vec(1,1,0,0,      0,0,      1,0, 32'h104, 32'hC000_0100, 32'h100, 0, 32'h0, 1, 0);
        vec(1,0,0,0,      1,32'h10, 0,0, 32'h10, 32'h0, 32'h0, 0, 32'h0, 0, 1);
        vec(1,0,0,0,      0,0,      0,0, P_ADDR, 32'hC000_0010, 32'h10, P_PT, P_TGT, 1, 0);
        // Four not-taken saturate at SNT; one taken then gives WNT (predicts not taken)
        vec(1,1,0,0,      0,0,      1,0, P_ADDR, 32'hC000_0010, 32'h10, P_PT, P_TGT, 1, 0);
        vec(1,1,0,0,      0,0,      1,0, P_ADDR, 32'hC000_0010, 32'h10, P_PT, P_TGT, 1, 0);
        vec(1,1,0,0,      0,0,      1,0, P_ADDR, 32'hC000_0010, 32'h10, P_PT, P_TGT, 1, 0);
        vec(1,1,0,0,      0,0,      1,0, P_ADDR, 32'hC000_0010, 32'h10, P_PT, P_TGT, 1, 0);
        vec(1,1,0,0,      0,0,      1,1, P_ADDR, 32'hC000_0010, 32'h10, P_PT, P_TGT, 1, 0);
        vec(1,0,0,0,      1,32'h10, 0,0, 32'h10, 32'h0, 32'h0, 0, 32'h0, 0, 1);
        vec(1,0,0,0,      0,0,      0,0, 32'h14, 32'hC000_0010, 32'h10, 0, 32'h0, 1, 0);
        // PC wraps from FFFF_FFFC to 0
        vec(1,0,0,0,      1,32'hFFFF_FFFC, 0,0, 32'hFFFF_FFFC, 32'h0, 32'h0, 0, 32'h0, 0, 1);
        vec(1,0,0,0,      0,0,      0,0, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 32'h0, 1, 0);
        // Reset wins over stall and redirect; predictor tables are cleared
        vec(0,1,0,0,      1,32'h80, 1,1, 32'h0, 32'h0, 32'h0, 0, 32'h0, 0, 0);
        vec(1,0,0,0,      1,32'h10, 0,0, 32'h10, 32'h0, 32'h0, 0, 32'h0, 0, 1);
        vec(1,0,0,0,      0,0,      0,0, 32'h14, 32'hC000_0010, 32'h10, 0, 32'h0, 1, 0);
        rst_n = 1'b1; stall = 1'b1; ex_redirect = 1'b0; id_redirect = 1'b0; ex_br_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("scoreboard_drain", vec_id, sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_predict_stage.md
Name: fetch_predict_stage

Overview:
Instruction-fetch stage with dynamic branch prediction and the IF/ID pipeline register. It sits directly upstream of decode and the hazard/forwarding unit, and consumes that unit's Stall output to freeze PC and IF/ID. Redirects are applied from EX (branch resolution and mispredict) and from ID (JR/CALL/JMP targets). A direct-mapped 2-bit-counter branch history table with a tagged target buffer (BHT/BTB) produces next-PC predictions.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
IDX_W, 4, BHT/BTB index width (2**IDX_W entries)
NOP_INSTR, 32'h0000_0000, instruction word injected on flush/reset

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  reset, synchronous, active-low
stall  in  1  load-use stall from hazard unit; hold PC and IF/ID
imem_addr  out  32  fetch address (= PC register, combinational)
imem_data  in  32  instruction at imem_addr, same cycle
id_redirect  in  1  ID-stage unconditional jump resolved
id_redirect_pc  in  32  ID jump target
ex_redirect  in  1  EX mispredict or late redirect
ex_redirect_pc  in  32  correct next PC from EX
ex_br_valid  in  1  EX holds a resolved conditional branch; update predictor
ex_br_pc  in  32  PC of that branch
ex_br_taken  in  1  actual outcome
ex_br_target  in  32  actual taken target
if_id_instr  out  32  IF/ID instruction
if_id_pc  out  32  IF/ID PC
if_id_pred_taken  out  1  prediction made for this instruction
if_id_pred_target  out  32  predicted target (valid when pred_taken)
if_id_valid  out  1  0 = bubble

Behaviour:
- Reset (rst_n=0 at edge): PC=RESET_PC; if_id_instr=NOP_INSTR; if_id_pc=0; if_id_pred_taken=0; if_id_pred_target=0; if_id_valid=0; all BHT counters=2'b01; all BTB valid=0.
- Index = PC[IDX_W+1:2]; tag = PC[31:IDX_W+2]. Lookup on the current PC is combinational from registered tables. Hit = valid && tag match.
- pred_taken = hit && counter[1]; pred_next = pred_taken ? btb_target : PC+4. PC arithmetic is 32-bit modulo; wrap from 32'hFFFF_FFFC to 0 is allowed.
- Next-state priority, per edge:
  1. ex_redirect: PC=ex_redirect_pc; IF/ID flushed (instr=NOP_INSTR, valid=0, pred_taken=0). Overrides stall.
  2. id_redirect && !stall: PC=id_redirect_pc; IF/ID flushed. id_redirect is ignored while stall=1.
  3. stall: PC and all IF/ID fields hold.
  4. Otherwise: PC=pred_next; IF/ID captures {imem_data, PC, pred_taken, pred_next if taken else 0, valid=1}.
- Fetch latency is 1 cycle from PC to IF/ID.
- Predictor update when ex_br_valid, independent of stall and redirect:
  - Hit at ex_br_pc: counter saturating ±1 (no wrap past 00 or 11); if taken, BTB target=ex_br_target.
  - Miss and taken: allocate the entry (valid=1, tag, target, counter=2'b10).
  - Miss and not taken: no change.
- Same-cycle update and lookup on one index: lookup sees the pre-update value.
- Reset mid-redirect or mid-stall: reset wins. All pending state is discarded.

Optional Feature:
FETCH_PREDICT_EN
- Defined: BHT/BTB behave as described above.
- Undefined: tables are not instantiated; pred_taken=0 and pred_next=PC+4; ex_br_* inputs are ignored; if_id_pred_taken and if_id_pred_target are tied to 0. Redirect and stall behaviour are unchanged.

Decomposition:
- Shared package (cpu_pkg): NOP_INSTR, RESET_PC default, 2-bit counter encodings (SNT=00, WNT=01, WT=10, ST=11), and a redirect-source enum.
- One sub-module: bht_btb. It holds the tables, the combinational lookup port and the synchronous update port.
- The PC register, priority mux and IF/ID register stay in the top.

Test Plan:
- Reset then 3 cycles with imem_data=A,B,C: imem_addr 0→4→8; IF/ID = (A,0),(B,4) with valid=1; pred_taken=0.
- stall=1 for 2 cycles at PC=8: imem_addr stays 8 and IF/ID holds (B,4). After release, IF/ID=(C,8).
- Branch at 0x10 resolved taken to 0x40 twice via ex_br_valid: next fetch of 0x10 gives pred_taken=1, next PC=0x40, if_id_pred_target=0x40.
- Same-cycle stall=1 and ex_redirect=1 (pc 0x80): PC=0x80; IF/ID flushed (valid=0, instr=NOP_INSTR).
- id_redirect=1 (0x100) with stall=1: ignored, PC held. The same request with stall=0 gives PC=0x100 and IF/ID bubble.
- Counter saturation: at ST, a taken update stays ST; four not-taken updates reach SNT and the next is still SNT. Prediction not-taken once the counter is below WT.
